// File: rtl/background_fetch.sv
// -----------------------------------------------------------------------------
// background_fetch
//
// Reads a stored background image out of a synchronous ROM and turns it into a
// valid/ready pixel stream. A start pulse latches the screen anchor and begins a
// row-major scan of the image. Visible pixels are fetched from ROM, buffered in
// a 2-entry FIFO together with their screen coordinates, decoded from RGB565 to
// 8-bit RGB and presented downstream. Pixels that land off-screen are never
// fetched and never emitted.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle frame request, honoured only when idle
//   anchor_x, anchor_y   screen position of image pixel (0,0), latched on start
//   busy                 frame in progress (drops in the cycle done pulses)
//   done                 one-cycle pulse when the frame has fully drained
//   rom_en, rom_addr     ROM read strobe and word address (row*IMAGE_WIDTH+col)
//   rom_data             RGB565 word, valid the cycle after rom_en
//   px_valid, px_ready   pixel stream handshake
//   r_out, g_out, b_out  decoded colour of the head pixel
//   x_out, y_out         screen coordinates of the head pixel
// -----------------------------------------------------------------------------
module background_fetch #(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int ADDR_WIDTH    = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9:0]            anchor_x,
  input  logic [9:0]            anchor_y,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [7:0]            r_out,
  output logic [7:0]            g_out,
  output logic [7:0]            b_out,
  output logic [9:0]            x_out,
  output logic [9:0]            y_out
);

  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  x;
    logic [9:0]  y;
  } entry_t;

  state_t state, state_nxt;

  // Scan position and the address of the current row's first word.
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [9:0]            anchor_x_q;
  logic [9:0]            anchor_y_q;

  // One read in flight: coordinates wait here until the ROM word returns.
  logic                  infl_valid;
  logic [9:0]            infl_x;
  logic [9:0]            infl_y;

  // Two-entry pixel buffer.
  entry_t                fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  entry_t                head;

  logic [10:0]           sx;
  logic [10:0]           sy;
  logic                  visible;
  logic                  last_col;
  logic                  last_row;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit_level;
  logic                  issue_ok;
  logic                  advance;
  logic                  accept_start;

  // Screen coordinates are 11 bits so an anchor near the right/bottom edge
  // plus a column/row offset cannot wrap back on-screen.
  assign sx       = {1'b0, anchor_x_q} + 11'(col);
  assign sy       = {1'b0, anchor_y_q} + 11'(row);
  assign visible  = (sx < 11'(SCREEN_WIDTH)) && (sy < 11'(SCREEN_HEIGHT));
  assign last_col = (col == CW'(IMAGE_WIDTH - 1));
  assign last_row = (row == RW'(IMAGE_HEIGHT - 1));

  assign push     = infl_valid;
  assign px_valid = (fifo_count != 2'd0);
  assign pop      = px_valid && px_ready;

  // Count everything that will occupy a buffer slot after this cycle. Taking
  // the same-cycle pop into account is what lets a full pipeline keep issuing
  // one read per cycle.
  assign credit_level = 3'(fifo_count) + 3'(infl_valid) - 3'(pop);
  assign issue_ok     = (credit_level < 3'd2);

  assign rom_addr = row_base + ADDR_WIDTH'(col);

  // ---------------------------------------------------------------------------
  // FSM: next state and per-cycle controls
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    rom_en       = 1'b0;
    advance      = 1'b0;
    accept_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (visible) begin
          rom_en  = issue_ok;
          advance = issue_ok;
        end else begin
          advance = 1'b1;
        end
        if (advance && last_col && last_row) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!infl_valid && (fifo_count == 2'd0)) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan counters and anchor latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      anchor_x_q <= '0;
      anchor_y_q <= '0;
    end else if (accept_start) begin
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      anchor_x_q <= anchor_x;
      anchor_y_q <= anchor_y;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        if (last_row) begin
          row      <= '0;
          row_base <= '0;
        end else begin
          row      <= row + RW'(1);
          row_base <= row_base + ADDR_WIDTH'(IMAGE_WIDTH);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight register: coordinates ride alongside the outstanding ROM read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_valid <= 1'b0;
      infl_x     <= '0;
      infl_y     <= '0;
    end else begin
      infl_valid <= rom_en;
      if (rom_en) begin
        infl_x <= sx[9:0];
        infl_y <= sy[9:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel buffer
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; occupancy and pointers are reset
  // instead, and the outputs are gated by px_valid, so stale contents are
  // never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{data: rom_data, x: infl_x, y: infl_y};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head-of-buffer decode: RGB565 widened by replicating the top bits
  // ---------------------------------------------------------------------------
  assign head  = fifo_mem[rd_ptr];
  assign r_out = px_valid ? {head.data[15:11], head.data[15:13]} : 8'd0;
  assign g_out = px_valid ? {head.data[10:5],  head.data[10:9]}  : 8'd0;
  assign b_out = px_valid ? {head.data[4:0],   head.data[4:2]}   : 8'd0;
  assign x_out = px_valid ? head.x : 10'd0;
  assign y_out = px_valid ? head.y : 10'd0;

endmodule

// File: tb/tb_background_fetch.sv
// -----------------------------------------------------------------------------
// tb_background_fetch
//
// Directed bench for background_fetch on a 6x4 screen with a 4x3 image.
// A small ROM model answers reads one cycle later; a negedge monitor records
// issued addresses and accepted pixels, which are compared against an
// expected list built from the anchor and the screen bounds.
// -----------------------------------------------------------------------------
module tb_background_fetch;

  localparam int SW = 6;
  localparam int SH = 4;
  localparam int IW = 4;
  localparam int IH = 3;
  localparam int AW = 4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [9:0]    anchor_x;
  logic [9:0]    anchor_y;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0;
  logic          px_valid;
  logic          px_ready;
  logic [7:0]    r_out;
  logic [7:0]    g_out;
  logic [7:0]    b_out;
  logic [9:0]    x_out;
  logic [9:0]    y_out;

  always #5 clk = ~clk;

  background_fetch #(
    .SCREEN_WIDTH (SW),
    .SCREEN_HEIGHT(SH),
    .IMAGE_WIDTH  (IW),
    .IMAGE_HEIGHT (IH),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .anchor_x(anchor_x),
    .anchor_y(anchor_y),
    .busy    (busy),
    .done    (done),
    .rom_en  (rom_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .px_valid(px_valid),
    .px_ready(px_ready),
    .r_out   (r_out),
    .g_out   (g_out),
    .b_out   (b_out),
    .x_out   (x_out),
    .y_out   (y_out)
  );

  // ROM model: synchronous read, data one cycle after the strobe.
  logic [15:0] rom_mem [16];
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  pix_t got_q[$];
  int   addr_q[$];
  int   issued, popped, max_out, done_cnt, done_cyc, first_valid_cyc, stall_err;
  logic prev_stall;
  pix_t prev_pix;
  pix_t cur;
  assign cur = {x_out, y_out, r_out, g_out, b_out};

  always @(negedge clk) begin
    if (rom_en) begin
      addr_q.push_back(int'(rom_addr));
      issued++;
    end
    if (px_valid && px_ready) begin
      got_q.push_back(cur);
      popped++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (px_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall && (cur != prev_pix || !px_valid)) stall_err++;
    prev_stall = px_valid && !px_ready;
    prev_pix   = cur;
  end

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    issued          = 0;
    popped          = 0;
    max_out         = 0;
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
    stall_err       = 0;
    prev_stall      = 1'b0;
  endtask

  // Backpressure driver: fixed 8-step ready pattern when enabled.
  logic       bp_mode = 1'b0;
  logic [7:0] ready_pat = 8'b1001_0110;
  initial begin
    int idx = 0;
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        px_ready = ready_pat[idx];
        idx      = (idx + 1) % 8;
      end else begin
        px_ready = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-stream model
  // ---------------------------------------------------------------------------
  pix_t exp_q[$];
  int   exp_addr_q[$];

  function automatic pix_t model_pix(input int addr, input int x, input int y);
    logic [15:0] d;
    pix_t p;
    d   = rom_mem[addr];
    p.x = 10'(x);
    p.y = 10'(y);
    p.r = {d[15:11], d[15:13]};
    p.g = {d[10:5], d[10:9]};
    p.b = {d[4:0], d[4:2]};
    return p;
  endfunction

  task automatic build_expected(input int ax, input int ay);
    exp_q.delete();
    exp_addr_q.delete();
    for (int row = 0; row < IH; row++) begin
      for (int col = 0; col < IW; col++) begin
        if (ax + col < SW && ay + row < SH) begin
          exp_q.push_back(model_pix(row * IW + col, ax + col, ay + row));
          exp_addr_q.push_back(row * IW + col);
        end
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    check($sformatf("%s.npix", tag), got_q.size(), exp_q.size());
    check($sformatf("%s.naddr", tag), addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.pix%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
      check($sformatf("%s.addr%0d", tag, i), addr_q[i], exp_addr_q[i]);
    check($sformatf("%s.done_cnt", tag), done_cnt, 1);
    check($sformatf("%s.stall_err", tag), stall_err, 0);
    check($sformatf("%s.over_credit", tag), max_out > 2, 0);
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s.busy", tag), busy, 0);
    check($sformatf("%s.done", tag), done, 0);
    check($sformatf("%s.rom_en", tag), rom_en, 0);
    check($sformatf("%s.px_valid", tag), px_valid, 0);
    check($sformatf("%s.rom_addr", tag), rom_addr, 0);
    check($sformatf("%s.pixel", tag), cur, 0);
  endtask

  int start_cyc;

  task automatic start_frame(input logic [9:0] ax, input logic [9:0] ay, input string tag);
    @(posedge clk);
    #1;
    anchor_x = ax;
    anchor_y = ay;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    check($sformatf("%s.busy_after_start", tag), busy, 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s.done_seen", tag), done_cnt != 0, 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rom_mem[0] = 16'hF800;
    rom_mem[1] = 16'h07E0;
    rom_mem[2] = 16'h001F;
    rom_mem[3] = 16'h8410;
    for (int i = 4; i < 16; i++) rom_mem[i] = 16'(i * 16'h0843 + 16'h1357);

    rst      = 1'b1;
    start    = 1'b0;
    anchor_x = '0;
    anchor_y = '0;
    clear_mon();
    settle(3);
    check_zero("reset");
    rst = 1'b0;

    // Basic frame plus latency / throughput.
    clear_mon();
    start_frame(10'd0, 10'd0, "basic");
    wait_done(200, "basic");
    settle(3);
    build_expected(0, 0);
    compare_frame("basic");
    check("basic.first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("basic.done_lat", done_cyc - start_cyc, IW * IH + 2);
    check("basic.busy_after_done", busy, 0);

    // Decode, hand-computed from the first four ROM words.
    if (got_q.size() >= 4) begin
      check("dec.F800", {got_q[0].r, got_q[0].g, got_q[0].b}, 24'hFF0000);
      check("dec.07E0", {got_q[1].r, got_q[1].g, got_q[1].b}, 24'h00FF00);
      check("dec.001F", {got_q[2].r, got_q[2].g, got_q[2].b}, 24'h0000FF);
      check("dec.8410", {got_q[3].r, got_q[3].g, got_q[3].b}, 24'h848284);
    end else begin
      check("dec.size", got_q.size(), 4);
    end

    // Clipping: only the top-left 2x2 of the image lands on screen.
    clear_mon();
    start_frame(10'd4, 10'd2, "clip");
    wait_done(200, "clip");
    settle(3);
    build_expected(4, 2);
    compare_frame("clip");
    if (addr_q.size() == 4 && got_q.size() == 4) begin
      check("clip.addr_list", {addr_q[0][7:0], addr_q[1][7:0], addr_q[2][7:0], addr_q[3][7:0]},
            32'h00010405);
      check("clip.xy_first", {got_q[0].x, got_q[0].y}, {10'd4, 10'd2});
      check("clip.xy_last", {got_q[3].x, got_q[3].y}, {10'd5, 10'd3});
    end else begin
      check("clip.count", addr_q.size(), 4);
    end

    // Backpressure with a partially clipped right column.
    clear_mon();
    bp_mode = 1'b1;
    start_frame(10'd3, 10'd0, "bp");
    wait_done(400, "bp");
    settle(3);
    bp_mode = 1'b0;
    build_expected(3, 0);
    compare_frame("bp");

    // Fully clipped image, with a start while busy that must be ignored.
    clear_mon();
    start_frame(10'd800, 10'd0, "clipall");
    settle(3);
    anchor_x = 10'd0;
    start    = 1'b1;
    settle(1);
    start    = 1'b0;
    wait_done(200, "clipall");
    settle(4);
    check("clipall.npix", got_q.size(), 0);
    check("clipall.reads", issued, 0);
    check("clipall.done_cnt", done_cnt, 1);
    check("clipall.done_lat", done_cyc - start_cyc, IW * IH);
    check("clipall.busy_after", busy, 0);

    // Reset in the middle of a frame, then a clean frame.
    clear_mon();
    bp_mode = 1'b1;
    start_frame(10'd0, 10'd0, "midrst");
    settle(5);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    settle(2);
    check("midrst.no_done", done_cnt, 0);
    rst     = 1'b0;
    bp_mode = 1'b0;
    clear_mon();
    start_frame(10'd0, 10'd0, "after_rst");
    wait_done(200, "after_rst");
    settle(3);
    build_expected(0, 0);
    compare_frame("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
